// File: rtl/cph_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cph_out_fifo
// Purpose  : DEPTH-entry output FIFO for 34-bit ciphertext words with a
//            per-word end-of-message marker, valid/ready output handshake,
//            sticky overflow flag and a completed-message counter.
// Options  : define CPH_PARITY_EN to store per-entry even parity and expose
//            out_par / par_err.
// Revision : 1.0  initial release
// ============================================================================
module cph_out_fifo #(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 8,
  parameter int MCNT_W = 16
) (
  input  logic                   clk_2,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [MCNT_W-1:0]      msg_count
`ifdef CPH_PARITY_EN
  ,
  output logic                   out_par,
  output logic                   par_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef CPH_PARITY_EN
  localparam int EW = DATA_W + 2;   // {parity, last, data}
`else
  localparam int EW = DATA_W + 1;   // {last, data}
`endif
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  // Storage is deliberately not reset; only pointers, count and flags are.
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [MCNT_W-1:0] msg_count_q, msg_count_d;
  logic [EW-1:0]     w_head;
  logic [EW-1:0]     w_entry;
  logic              w_push;
  logic              w_pop;
`ifdef CPH_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  // Handshake, head-entry decode and next-state for pointers, count and flags.
  always_comb begin
    in_ready  = (count_q != C_FULL);
    out_valid = (count_q != '0);
    w_push    = in_valid & in_ready;
    w_pop     = out_valid & out_ready;
    // Gate the head with out_valid so an empty FIFO shows zeros, not stale data.
    w_head    = out_valid ? mem_q[rd_ptr_q] : '0;
    out_data  = w_head[DATA_W-1:0];
    out_last  = w_head[DATA_W];
`ifdef CPH_PARITY_EN
    out_par   = w_head[DATA_W+1];
    w_entry   = {^in_data, in_last, in_data};
`else
    w_entry   = {in_last, in_data};
`endif

    wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A rejected offer sets the flag; setting takes priority over clearing.
    if (in_valid & ~in_ready) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    msg_count_d = (w_pop & out_last) ? msg_count_q + MCNT_W'(1) : msg_count_q;

`ifdef CPH_PARITY_EN
    if (w_pop & ((^out_data) != out_par)) begin
      par_err_d = 1'b1;
    end else if (clr_ovf) begin
      par_err_d = 1'b0;
    end else begin
      par_err_d = par_err_q;
    end
`endif
  end

  // Entry write on accepted push.
  always_ff @(posedge clk_2) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_entry;
    end
  end

  // Pointer, occupancy and flag registers; reset discards all stored entries.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      msg_count_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      msg_count_q <= msg_count_d;
    end
  end

`ifdef CPH_PARITY_EN
  // Sticky parity-error flag.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign msg_count = msg_count_q;

endmodule
`default_nettype wire

// File: doc/cph_out_fifo.md
Name: cph_out_fifo

Overview:
- Downstream neighbour of the 34-bit ciphertext decode register stage.
- Buffers registered 34-bit ciphertext words in a DEPTH-entry FIFO and carries a per-word end-of-message marker.
- Presents the words to the output/host side over a valid/ready handshake.
- Decouples the fixed-rate decode stage from a consumer that can stall, and reports overflow and completed-message counts.

Parameters:
- DATA_W, 34, ciphertext word width; must match the decode stage output.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- MCNT_W, 16, width of the completed-message counter.

Ports:
- clk_2  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last are valid this cycle.
- in_data  input  DATA_W  ciphertext word from the decode stage.
- in_last  input  1  word is the final word of a message.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_valid  output  1  out_data/out_last hold the head entry.
- out_data  output  DATA_W  head ciphertext word.
- out_last  output  1  end-of-message marker of the head word.
- out_ready  input  1  consumer accepts the head word this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a word was offered while full.
- clr_ovf  input  1  synchronous clear of overflow.
- msg_count  output  MCNT_W  number of popped words carrying last=1.

Behaviour:
- Reset (rst high, asynchronous):
  - Read pointer, write pointer, count, overflow and msg_count are 0.
  - out_valid=0, out_data=0, out_last=0, in_ready=1 (after reset state settles).
  - Asserting reset mid-operation discards all stored entries immediately; no partial message survives.
- Storage:
  - DEPTH x (DATA_W+1) array; the extra bit is last.
  - Array contents are not reset; only pointers, count and flags are.
- Handshake signals:
  - in_ready = (count != DEPTH), combinational from registered count.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - out_valid = (count != 0).
  - out_data/out_last = mem[rd_ptr], read combinationally from the registered pointer.
- Latency: a word pushed in cycle N is visible on out_valid/out_data in cycle N+1. There is no same-cycle fall-through.
- Pointers: log2(DEPTH) bits, increment on push/pop respectively, wrap naturally DEPTH-1 -> 0.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push & pop together.
- Boundary conditions:
  - Full (count=DEPTH): in_ready=0, so a simultaneous pop does not admit a push in the same cycle; the push becomes possible the next cycle.
  - Empty (count=0): out_valid=0 and out_ready is ignored. A push and out_ready in the same cycle: push only.
  - Simultaneous push/pop at 0<count<DEPTH: both occur and count is held.
- overflow:
  - Set on in_valid & !in_ready.
  - Cleared on clr_ovf.
  - If set and clear coincide, set wins.
  - The offered word is dropped and the FIFO is unaffected.
- msg_count: +1 on pop with out_last=1; wraps 2^MCNT_W-1 -> 0.
- No state machine beyond the pointer/count datapath; all outputs are registered-derived with no combinational path from in_valid to out_valid.

Optional Feature:
- Macro: CPH_PARITY_EN.
- When defined:
  - Each entry stores an extra bit, the even parity of in_data at push (XOR reduction).
  - New output port out_par (1 bit) presents the stored parity of the head entry.
  - New sticky output par_err is set when a pop occurs and the XOR of out_data differs from out_par. It is cleared by rst or clr_ovf.
- When not defined: ports out_par/par_err and the extra storage bit do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle -> count=0, out_valid=0, in_ready=1, overflow=0, msg_count=0; assert rst mid-burst after 3 pushes -> count returns to 0 asynchronously.
- Push 34'h2_0000_0001 with last=0, out_ready=0 -> next cycle out_valid=1, out_data=34'h2_0000_0001, count=1.
- Push DEPTH=8 words 1..8 with out_ready=0, then hold in_valid with word 9 -> in_ready=0 at count=8, overflow=1, word 9 absent. Drain -> order 1..8. Pulse clr_ovf -> overflow=0.
- At count=4, push and pop together for 10 cycles -> count stays 4, output order preserved across pointer wrap.
- Three messages of lengths 1, 3, 2 (last on the final word of each) pushed and drained -> msg_count=3; when preloaded to 16'hFFFF, one more last-pop -> 0.
- With CPH_PARITY_EN: push 34'h0_0000_0007 -> out_par=1, par_err stays 0; force a corrupted stored word via bench backdoor -> par_err=1 after pop.
